npu_result_drain: RTL
=====================

# npu_result_drain

Downstream stage of the 10x10 weight-stationary systolic array. On the array's completion strobe it captures the full N x N signed 16-bit result matrix into a local buffer, frees the array for its next job, and streams the elements out row-major over a valid/ready interface. Each element is requantized (arithmetic shift, optional ReLU, saturation to OUT_W bits), and saturation events are counted per frame.

## Interface
- N, 10, matrix dimension; must match the array.
- IN_W, 16, signed width of the array result elements.
- OUT_W, 8, signed width of the streamed output elements; 2 ≤ OUT_W ≤ IN_W.
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- done_in  in  1  array completion; level or pulse, only its rising edge is used.
- res_in  in  N x N x IN_W signed  array result matrix.
- shift  in  4  right-shift amount; sampled at capture.
- relu_en  in  1  clamp negatives to 0; sampled at capture.
- out_ready  in  1  consumer ready.
- out_valid  out  1  out_data, out_row, out_col and out_last are valid.
- out_data  out  OUT_W signed  requantized element.
- out_row, out_col  out  4 each  element index.
- out_last  out  1  high with element (N-1, N-1).
- busy  out  1  high in ARM and STREAM.
- frame_done  out  1  one-cycle pulse after the last handshake.
- overrun  out  1  one-cycle pulse when a done_in rise is ignored.
- sat_cnt  out  16  saturations in the current or last frame; sticks at 0xFFFF.

## Operation
- States: IDLE, ARM, STREAM. Enum lives in the package.
- done_q is registered every cycle. rise = done_in & ~done_q.
- IDLE: rise -> ARM.
- ARM, one cycle:
  - copy res_in into buf[N][N];
  - latch shift and relu_en;
  - clear sat_cnt;
  - set row = col = 0;
  - -> STREAM.
  - The array's result register settles one cycle after its done rises, so res_in is sampled one cycle after the rise.
- STREAM: out_valid = 1 and presents buf[row][col] after requantization.
- Handshake = out_valid & out_ready. On each handshake:
  - col increments; at col = N-1 it wraps to 0 and row increments;
  - at (N-1, N-1) go to IDLE and pulse frame_done.
- Requantization:
  - v = buf >>> shift, arithmetic (rounds toward −inf); shift ≥ IN_W gives 0 or −1.
  - If relu_en and v < 0, v = 0.
  - Clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - A clamp counts one saturation, added on that element's handshake only, never on stalled cycles.
- Stall: while out_valid & ~out_ready, all outputs hold stable.
- A rise in ARM or STREAM: pulse overrun, keep streaming the buffered frame unchanged, do not re-arm.
- A rise on the same cycle as the final handshake is also overrun. A new frame needs a rise seen in IDLE.
- Reset values: every output 0, state IDLE, done_q 0, buffer contents don't-care.
- rst_n assertion mid-stream aborts the frame immediately and asynchronously. No frame_done is generated.

## Timing
- Rise seen at edge k: ARM after edge k; capture at edge k+1; out_valid high after edge k+1 with element (0,0).
- With out_ready held high: one element per cycle, 100 cycles per frame.
- frame_done is high the cycle after the last handshake, and busy is 0 that same cycle.
- Minimum spacing between accepted frames: N*N + 2 cycles.
- out_data comes from a register fed by the requant path; no combinational path from out_ready to out_data.

## Structure
- npu_pkg holds N, IN_W, OUT_W defaults and drain_state_t {IDLE, ARM, STREAM}, shared with the array.
- Sub-module requant_sat, combinational:
  - inputs: value, shift, relu_en;
  - outputs: clamped value and sat flag.
- Buffer, index counters, FSM and sat_cnt live in npu_result_drain.

## Test plan
- Reset: hold rst_n low with done_in toggling -> all outputs 0, busy 0, no output activity.
- Ramp: res_in[i][j] = 10i + j, shift 0, relu 0, ready high, done_in rise -> out_valid from edge k+1, data 0..99 in order, out_last on 99, frame_done one cycle later, sat_cnt 0.
- Saturation:
  - all 300, shift 0 -> 127 ×100, sat_cnt 100;
  - all −300 -> −128 ×100;
  - all 300, shift 2 -> 75 ×100, sat_cnt 0.
- ReLU/shift:
  - −5, relu_en 1 -> 0 with no saturation counted;
  - −5, shift 1, relu 0 -> −3.
- Backpressure: ramp frame with ready low for 5 cycles at element 37, then toggling 1/0 -> 37 held stable with indices (3,7) while stalled, exactly 100 handshakes, no duplicates or skips.
- Overrun/abort:
  - done_in rise at element 50 -> overrun pulse, frame continues 50..99 unchanged;
  - rst_n low at element 20 -> outputs 0 immediately, no frame_done, next rise starts at (0,0).

Source files
------------

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU systolic array and its result drain.
//   NPU_N      : matrix dimension of the array
//   NPU_IN_W   : signed width of array result elements
//   NPU_OUT_W  : signed width of requantized output elements
//   drain_state_t : result drain FSM states
package npu_pkg;

   localparam int NPU_N     = 10;
   localparam int NPU_IN_W  = 16;
   localparam int NPU_OUT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      STREAM = 2'd2
   } drain_state_t;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic right shift, optional ReLU,
// saturation to OUT_W signed bits.
//   value   : signed IN_W input element
//   shift   : right-shift amount (arithmetic, rounds toward -inf)
//   relu_en : clamp negative shifted values to zero
//   data    : OUT_W signed result
//   sat     : high when the result was clamped to the OUT_W range
module requant_sat #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8
) (
   input  logic signed [IN_W-1:0]  value,
   input  logic        [3:0]       shift,
   input  logic                    relu_en,
   output logic        [OUT_W-1:0] data,
   output logic                    sat
);

   localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
   localparam int MIN_I = -(1 << (OUT_W - 1));
   localparam logic signed [IN_W-1:0] MAX_V = IN_W'(MAX_I);
   localparam logic signed [IN_W-1:0] MIN_V = IN_W'(MIN_I);

   logic signed [IN_W-1:0] shifted;
   logic signed [IN_W-1:0] v;

   always_comb begin
      // Shifts of IN_W or more leave only sign bits: 0 or -1.
      shifted = value >>> shift;
      v       = shifted;
      if (relu_en && shifted[IN_W-1]) begin
         v = '0;
      end
      data = v[OUT_W-1:0];
      sat  = 1'b0;
      if (v > MAX_V) begin
         data = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end else if (v < MIN_V) begin
         data = MIN_V[OUT_W-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/npu_result_drain.sv
// Result drain for the NxN systolic array. On a rising edge of done_in the
// result matrix is captured into a local buffer (one cycle later, once the
// array's result register has settled), then streamed row-major over a
// valid/ready interface with per-element requantization and a per-frame
// saturation count.
//   clk, rst_n      : clock, asynchronous active-low reset
//   done_in         : array completion (rising edge used)
//   res_in          : flat NxN matrix, element (i,j) at [(i*N+j)*IN_W +: IN_W]
//   shift, relu_en  : requant controls, sampled at capture
//   out_ready       : consumer ready
//   out_valid/out_data/out_row/out_col/out_last : output stream
//   busy            : frame in ARM or STREAM
//   frame_done      : pulse the cycle after the final handshake
//   overrun         : pulse when a done_in rise is ignored
//   sat_cnt         : saturations in current/last frame, sticky at 0xFFFF
//
// state  | meaning
// IDLE   | waiting for a done_in rise
// ARM    | capturing res_in, shift, relu_en; preloading element (0,0)
// STREAM | presenting buffered elements until (N-1,N-1) is accepted
module npu_result_drain
   import npu_pkg::*;
#(
   parameter int N     = NPU_N,
   parameter int IN_W  = NPU_IN_W,
   parameter int OUT_W = NPU_OUT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  done_in,
   input  logic [N*N*IN_W-1:0]   res_in,
   input  logic [3:0]            shift,
   input  logic                  relu_en,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [OUT_W-1:0]      out_data,
   output logic [3:0]            out_row,
   output logic [3:0]            out_col,
   output logic                  out_last,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun,
   output logic [15:0]           sat_cnt
);

   localparam logic [3:0] LAST_IDX = 4'(N - 1);

   drain_state_t state_q;

   logic                   done_q;
   logic                   rise;
   logic                   hs;
   logic                   at_last;
   logic [3:0]             row_q;
   logic [3:0]             col_q;
   logic [3:0]             nrow;
   logic [3:0]             ncol;
   logic [3:0]             shift_q;
   logic                   relu_q;
   logic                   sat_q;
   logic signed [IN_W-1:0] mem_q [N][N];

   logic signed [IN_W-1:0] rq_value;
   logic [3:0]             rq_shift;
   logic                   rq_relu;
   logic [OUT_W-1:0]       rq_data;
   logic                   rq_sat;

   assign rise      = done_in & ~done_q;
   assign out_valid = (state_q == STREAM);
   assign busy      = (state_q != IDLE);
   assign hs        = out_valid & out_ready;
   assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
   assign out_last  = out_valid & at_last;
   assign out_row   = row_q;
   assign out_col   = col_q;

   // The requant path always looks one element ahead so out_data can be
   // registered: in ARM it sees (0,0) straight from res_in with the live
   // controls, in STREAM it sees the buffered element after (row,col).
   always_comb begin
      ncol = col_q + 4'd1;
      nrow = row_q;
      if (col_q == LAST_IDX) begin
         ncol = '0;
         nrow = row_q + 4'd1;
      end
      if (at_last) begin
         nrow = '0;
      end
      if (state_q == ARM) begin
         rq_value = $signed(res_in[IN_W-1:0]);
         rq_shift = shift;
         rq_relu  = relu_en;
      end else begin
         rq_value = mem_q[nrow][ncol];
         rq_shift = shift_q;
         rq_relu  = relu_q;
      end
   end

   requant_sat #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_requant (
      .value   (rq_value),
      .shift   (rq_shift),
      .relu_en (rq_relu),
      .data    (rq_data),
      .sat     (rq_sat)
   );

   always_ff @(posedge clk) begin
      if (state_q == ARM) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               mem_q[i][j] <= $signed(res_in[(i*N+j)*IN_W +: IN_W]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         sat_q      <= 1'b0;
         out_data   <= '0;
         sat_cnt    <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         done_q     <= done_in;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_q <= ARM;
               end
            end
            ARM: begin
               if (rise) begin
                  overrun <= 1'b1;
               end
               shift_q  <= shift;
               relu_q   <= relu_en;
               sat_cnt  <= '0;
               row_q    <= '0;
               col_q    <= '0;
               out_data <= rq_data;
               sat_q    <= rq_sat;
               state_q  <= STREAM;
            end
            STREAM: begin
               if (rise) begin
                  overrun <= 1'b1;
               end
               if (hs) begin
                  // The saturation flag travels with the presented element,
                  // so it is counted once, on acceptance.
                  if (sat_q && (sat_cnt != 16'hFFFF)) begin
                     sat_cnt <= sat_cnt + 16'd1;
                  end
                  if (at_last) begin
                     state_q    <= IDLE;
                     frame_done <= 1'b1;
                     row_q      <= '0;
                     col_q      <= '0;
                  end else begin
                     row_q    <= nrow;
                     col_q    <= ncol;
                     out_data <= rq_data;
                     sat_q    <= rq_sat;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
